// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding, widths and weight base for the act/weight loader
package loader_pkg;

    localparam int LOADER_ADDR_W   = 11;
    localparam int LOADER_KIJ_W    = 4;
    localparam int LOADER_WGT_BASE = 1024;
    localparam int LOADER_WD_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACT_WR    = 3'd1,
        S_WGT_WR    = 3'd2,
        S_START     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/loader_watchdog.sv
// rtl/loader_watchdog.sv - cycle counter that flags a core that never reports done
module loader_watchdog
    import loader_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [LOADER_WD_W-1:0] r_cnt;

    // Restarted just before each wait begins, then counts every waiting cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expires on the TIMEOUT-th waiting cycle so the FSM leaves on the next edge
    assign o_expired = i_en && (r_cnt == LOADER_WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/act_wgt_loader.sv
// rtl/act_wgt_loader.sv - stream-to-SRAM activation/weight loader with core handshake (LOADER_TIMEOUT_EN adds the done watchdog)
module act_wgt_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = LOADER_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int M        = 6,
    parameter int COL      = 8,
    parameter int KIJ_NUM  = 9,
    parameter int WGT_BASE = LOADER_WGT_BASE,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    core_done,
    output logic                    sram_cen,
    output logic                    sram_wen,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [DATA_W-1:0]       sram_d,
    output logic                    core_start,
    output logic [LOADER_KIJ_W-1:0] kij,
    output logic                    busy,
    output logic                    run_done,
    output logic                    err
);

    // The watchdog counter is 8 bits wide, so the limit must fit in it
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("act_wgt_loader: TIMEOUT must be in 1..255");
    end

    loader_state_t           r_state;
    logic [ADDR_W-1:0]       r_cnt;
    logic [LOADER_KIJ_W-1:0] r_kij;
    logic                    r_in_ready;
    logic                    r_sram_cen;
    logic                    r_sram_wen;
    logic [ADDR_W-1:0]       r_sram_addr;
    logic [DATA_W-1:0]       r_sram_d;
    logic                    r_core_start;
    logic                    r_busy;
    logic                    r_run_done;
    logic                    r_done_d;

    logic w_accept;
    logic w_done_rise;
    logic w_act_last;
    logic w_wgt_last;
    logic w_kij_last;

    assign w_accept    = in_valid && r_in_ready;
    assign w_done_rise = core_done && !r_done_d;
    assign w_act_last  = (r_cnt == ADDR_W'(M * M - 1));
    assign w_wgt_last  = (r_cnt == ADDR_W'(COL - 1));
    assign w_kij_last  = (r_kij == LOADER_KIJ_W'(KIJ_NUM - 1));

`ifdef LOADER_TIMEOUT_EN
    logic r_err;
    logic w_wd_expired;

    loader_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (r_state == S_START),
        .i_en      (r_state == S_WAIT_DONE),
        .o_expired (w_wd_expired)
    );

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Single control FSM: streams the tiles into SRAM and sequences the core per kij
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_kij        <= '0;
            r_in_ready   <= 1'b0;
            r_sram_cen   <= 1'b1;
            r_sram_wen   <= 1'b1;
            r_sram_addr  <= '0;
            r_sram_d     <= '0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_run_done   <= 1'b0;
            r_done_d     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
        end else begin
            // The edge register follows core_done in every state so a held level never retriggers
            r_done_d     <= core_done;
            r_sram_cen   <= 1'b1;
            r_sram_wen   <= 1'b1;
            r_core_start <= 1'b0;
            r_run_done   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state    <= S_ACT_WR;
                        r_kij      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
                        r_err      <= 1'b0;
`endif
                    end
                end

                S_ACT_WR: begin
                    if (w_accept) begin
                        r_sram_cen  <= 1'b0;
                        r_sram_wen  <= 1'b0;
                        r_sram_addr <= r_cnt;
                        r_sram_d    <= in_data;
                        if (w_act_last) begin
                            r_cnt   <= '0;
                            r_state <= S_WGT_WR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                S_WGT_WR: begin
                    if (w_accept) begin
                        r_sram_cen  <= 1'b0;
                        r_sram_wen  <= 1'b0;
                        r_sram_addr <= ADDR_W'(WGT_BASE) + r_cnt;
                        r_sram_d    <= in_data;
                        r_cnt       <= r_cnt + 1'b1;
                        // Start is raised alongside the last weight write so the core sees a complete tile
                        if (w_wgt_last) begin
                            r_in_ready   <= 1'b0;
                            r_core_start <= 1'b1;
                            r_state      <= S_START;
                        end
                    end
                end

                S_START: begin
                    r_state <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (w_done_rise) begin
                        if (w_kij_last) begin
                            r_run_done <= 1'b1;
                            r_state    <= S_FINISH;
                        end else begin
                            r_kij      <= r_kij + 1'b1;
                            r_cnt      <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_WGT_WR;
                        end
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (w_wd_expired) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`endif
                end

                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign sram_cen   = r_sram_cen;
    assign sram_wen   = r_sram_wen;
    assign sram_addr  = r_sram_addr;
    assign sram_d     = r_sram_d;
    assign core_start = r_core_start;
    assign kij        = r_kij;
    assign busy       = r_busy;
    assign run_done   = r_run_done;

endmodule

// File: doc/act_wgt_loader.md
# act_wgt_loader

Host-side writer for the activation/weight SRAM that the core controller reads. It accepts a valid/ready stream of 32-bit words and writes one activation tile, then one weight tile per kernel position (kij), into the shared 2000-word SRAM. After each weight tile it pulses the core's start, then waits for the core's done before loading the next kij. It sits between the testbench/host stream and the SRAM port the core hands over while it is idle.

## Interface
- `ADDR_W`, 11: SRAM address width.
- `DATA_W`, 32: stream and SRAM word width.
- `M`, 6: input feature-map side; the activation tile is M*M words.
- `COL`, 8: weight words per kij.
- `KIJ_NUM`, 9: kernel positions per run (K*K).
- `WGT_BASE`, 1024: SRAM base address of the weight tile.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with `LOADER_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: start a run; sampled only in IDLE.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in DATA_W: stream word.
- `core_done` in 1: core finished the current kij (level; rising edge detected).
- `sram_cen` out 1: SRAM chip enable, active-low.
- `sram_wen` out 1: SRAM write enable, active-low.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_d` out DATA_W: SRAM write data.
- `core_start` out 1: one-cycle start pulse to the core.
- `kij` out 4: current kernel position, driven to the core.
- `busy` out 1: high in every state except IDLE.
- `run_done` out 1: one-cycle pulse when all KIJ_NUM positions complete.
- `err` out 1: sticky watchdog error; held at 0 without the macro.

## Operation
- States: IDLE, ACT_WR, WGT_WR, START, WAIT_DONE, FINISH.
- IDLE → ACT_WR on `go`. On this transition: `kij`=0, word counter=0, `err` cleared.
- ACT_WR:
  - `in_ready`=1. Each accepted word (`in_valid & in_ready`) is written to address = counter, for counter 0..M*M-1.
  - After word M*M-1: counter=0, go to WGT_WR.
- WGT_WR:
  - `in_ready`=1. Each accepted word is written to address WGT_BASE+counter, for counter 0..COL-1.
  - After word COL-1: go to START.
- START: `core_start`=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE:
  - On a `core_done` rising edge: if `kij`==KIJ_NUM-1, go to FINISH; else `kij`+1, counter=0, go to WGT_WR.
  - The activation tile is never rewritten within a run.
- FINISH: `run_done`=1 for one cycle, then IDLE.
- Cases that are ignored:
  - `in_ready`=0 outside ACT_WR and WGT_WR; `in_valid` there is ignored.
  - `go` while `busy` is ignored.
  - A `core_done` edge outside WAIT_DONE is ignored. The edge register still tracks `core_done`, so a level left high from a previous kij never retriggers.
- The SRAM is driven only during write cycles. At all other times `sram_cen`=1 and `sram_wen`=1; addr and data hold their last values.

## Timing
- Reset values: `in_ready` 0, `sram_cen` 1, `sram_wen` 1, `sram_addr` 0, `sram_d` 0, `core_start` 0, `kij` 0, `busy` 0, `run_done` 0, `err` 0. The state goes to IDLE.
- Reset asserted mid-run aborts immediately. Any partial tile is discarded, and the next `go` reloads from scratch.
- Write latency: all SRAM outputs are registered. An accept in cycle t produces `sram_cen`=0, `sram_wen`=0, addr and data in cycle t+1.
- Back-to-back accepts write on consecutive cycles. A bubble in `in_valid` produces an idle SRAM cycle (`cen`=1).
- The last weight accept is at t. The SRAM write is at t+1 and `core_start`=1 at t+1 (START state), so the write completes before the core leaves its idle state.
- `in_ready` is a registered function of state. It drops in the cycle after the final word of a tile is accepted, so no extra word is ever taken.
- Minimum run length: M*M + KIJ_NUM*(COL+2) + core time + 1 cycles.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles in WAIT_DONE and clears on entry to that state.
  - When it reaches TIMEOUT without a `core_done` edge: `err`=1 (sticky until the next accepted `go` or reset), `busy` drops and the state returns to IDLE without `run_done`.
- Not defined: no watchdog; WAIT_DONE waits indefinitely and `err` is tied to 0.

## Structure
- Shared package `loader_pkg`: state enum encoding, the `WGT_BASE` default, and address and kij widths, so the core controller uses the same weight base.
- Sub-module `loader_watchdog`: counter plus compare, instantiated only under `LOADER_TIMEOUT_EN`.
- Everything else is a single FSM plus one word counter.

## Test plan
- Reset, then `go` with 36 act words and 8 weight words streamed without gaps:
  - writes to 0..35, then 1024..1031;
  - `core_start` one cycle after the last weight accept;
  - `kij`=0.
- Drive `core_done` edges nine times, each after weight tiles fed as the bench expects:
  - `kij` steps 0→8, weights are rewritten at 1024..1031 each time;
  - `run_done` pulses exactly once, then `busy`=0.
- Random `in_valid` gaps with data pattern 0xA5000000+n:
  - the SRAM write sequence matches n with no drops or duplicates;
  - `cen`=1 in every gap cycle.
- Pulse `go` and hold `core_done` high during ACT_WR and WGT_WR: no state change, no extra start, and the stuck-high level never advances `kij`.
- Assert `reset` during WGT_WR of kij=3:
  - all outputs take their reset values immediately;
  - a fresh `go` restarts at address 0 with `kij`=0.
- With `LOADER_TIMEOUT_EN` and `TIMEOUT`=20, withhold `core_done`:
  - `err`=1 at 20 cycles in WAIT_DONE, `busy`=0, no `run_done`;
  - the next `go` clears `err`.
